fetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue. It keeps up to DEPTH instructions in flight or buffered against an in-order, multi-outstanding instruction memory, presents them to decode through the IF/ID boundary, and flushes on redirect. Halt detection, branch squash and NOP bubbles are handled locally. It sits between the PC/branch logic of execute and the decode stage.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the queue-entry layout for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR  = 16'h0800;
  localparam logic [15:0] HALT_INSTR = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        rerr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; the head is read straight from storage flops.
module fetch_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues sequential requests to an in-order memory, buffers
// responses in a prefetch queue, presents the head to decode and flushes on redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              IW       = 16,
  parameter int              AW       = 16,
  parameter int              DEPTH    = 4,
  parameter int              INC      = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          imem_rerr,
  output logic          ifid_valid,
  output logic [IW-1:0] ifid_instr,
  output logic [AW-1:0] ifid_pc,
  output logic [AW-1:0] ifid_pc2,
  output logic          ifid_halt,
  output logic          err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = IW + AW + 1;
  typedef logic [CW-1:0] cnt_t;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  cnt_t          outstanding_q, outstanding_d, drop_q, drop_d, count;
  logic          halted_q, halted_d, err_q, err_d;
  logic [EW-1:0] head;
  logic [IW-1:0] head_instr;
  logic [AW-1:0] head_pc, resp_pc, pc_inc;
  logic          head_rerr, pc_wrap;
  logic [CW:0]   inflight;
  logic          issue, accept, push, pop;

  // Handshakes: a request transfers when imem_req & imem_gnt in the same cycle; the
  // memory answers each transfer exactly once, in order, with a one-cycle imem_rvalid
  // pulse (no back-pressure). Decode takes the head when ifid_valid & ~stall.
  assign inflight  = {1'b0, count} + {1'b0, outstanding_q} + {1'b0, drop_q};
  assign imem_req  = ~rst & ~halted_q & ~redirect & (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req & imem_gnt;
  assign accept    = imem_rvalid & (drop_q == '0);
  assign push      = accept & ~redirect;
  assign pop       = ifid_valid & ~stall & ~redirect;

  // Requests are sequential, so the oldest outstanding PC is recovered arithmetically.
  assign resp_pc           = fetch_pc_q - AW'(outstanding_q) * AW'(INC);
  assign {pc_wrap, pc_inc} = {1'b0, fetch_pc_q} + (AW+1)'(INC);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    halted_d      = halted_q;
    err_d         = err_q | (ifid_valid & head_rerr);
    if (redirect) begin
      fetch_pc_d    = redirect_pc;
      outstanding_d = '0;
      drop_d        = drop_q + outstanding_q - cnt_t'(imem_rvalid);
      halted_d      = 1'b0;
    end else begin
      outstanding_d = outstanding_q + cnt_t'(issue) - cnt_t'(accept);
      drop_d        = drop_q - cnt_t'(imem_rvalid & (drop_q != '0));
      if (issue) begin
        fetch_pc_d = pc_inc;
        if (pc_wrap) err_d = 1'b1;
      end
      if (push && imem_rdata == IW'(HALT_INSTR)) halted_d = 1'b1;
      if (push && imem_rerr) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
    end
  end

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_rdata, resp_pc, imem_rerr}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign {head_instr, head_pc, head_rerr} = head;

  assign ifid_valid = (count != '0);
  assign ifid_instr = ifid_valid ? head_instr : IW'(NOP_INSTR);
  assign ifid_pc    = ifid_valid ? head_pc : '0;
  assign ifid_pc2   = ifid_pc + AW'(INC);
  assign ifid_halt  = ifid_valid & (head_instr == IW'(HALT_INSTR));
  assign err        = err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, checked every cycle
// against a queue-based reference model of the fetch stage.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int EW = $bits(fetch_entry_t);

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        imem_rerr;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc2;
  logic        ifid_halt;
  logic        err;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_rerr   (imem_rerr),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_pc2    (ifid_pc2),
    .ifid_halt   (ifid_halt),
    .err         (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: presented entries, PCs of live requests, responses to discard
  logic [EW-1:0] exp_q[$];
  logic [15:0]   pend_q[$];
  int            drop;
  logic [15:0]   m_pc;
  bit            m_halted;
  bit            m_err;

  // memory model: in-order pending requests with their earliest response cycle
  logic [15:0] mem_addr_q[$];
  int          mem_rdy_q[$];
  int          lat_max  = 0;
  int          gnt_pct  = 100;
  logic [15:0] halt_addr = 16'hFFFF;
  logic [15:0] err_addr  = 16'hFFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_rerr = 1'b0;
    exp_q.delete(); pend_q.delete(); drop = 0; m_pc = 16'h0000;
    m_halted = 0; m_err = 0;
    mem_addr_q.delete(); mem_rdy_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req",   imem_req,   32'd0);
    check("rst_valid", ifid_valid, 32'd0);
    check("rst_instr", ifid_instr, 32'(NOP_INSTR));
    check("rst_pc",    ifid_pc,    32'd0);
    check("rst_pc2",   ifid_pc2,   32'd2);
    check("rst_halt",  ifid_halt,  32'd0);
    check("rst_err",   err,        32'd0);
    rst = 1'b0;
  endtask

  // one clock: drive inputs, compare outputs with the model, advance model and memory
  task automatic cycle(input bit redir, input logic [15:0] rpc, input bit stl);
    bit           rv, re, e_valid, e_req, issue;
    logic [15:0]  rd, ra, p, e_pc2;
    fetch_entry_t h;
    @(negedge clk);
    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
    imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    rv = (mem_rdy_q.size() > 0) && (mem_rdy_q[0] <= cyc);
    if (rv) begin
      ra = mem_addr_q.pop_front();
      void'(mem_rdy_q.pop_front());
      rd = (ra == halt_addr) ? 16'h0000 : (ra | 16'h0001);
      re = (ra == err_addr);
    end else begin
      rd = 16'($urandom);
      re = 1'($urandom_range(0, 1));
    end
    imem_rvalid = rv;
    imem_rdata  = rd;
    imem_rerr   = re;
    #1;
    e_valid = (exp_q.size() > 0);
    h       = e_valid ? fetch_entry_t'(exp_q[0]) : '{instr: NOP_INSTR, pc: 16'h0, rerr: 1'b0};
    e_pc2   = h.pc + 16'd2;
    e_req   = !m_halted && !redir && (exp_q.size() + pend_q.size() + drop < 4);
    check("valid", ifid_valid, 32'(e_valid));
    check("instr", ifid_instr, 32'(h.instr));
    check("pc",    ifid_pc,    32'(h.pc));
    check("pc2",   ifid_pc2,   32'(e_pc2));
    check("halt",  ifid_halt,  32'(e_valid && h.instr == 16'h0000));
    check("req",   imem_req,   32'(e_req));
    check("addr",  imem_addr,  32'(m_pc));
    check("err",   err,        32'(m_err));
    if (imem_req && imem_gnt) begin
      mem_addr_q.push_back(imem_addr);
      mem_rdy_q.push_back(cyc + 1 + $urandom_range(0, lat_max));
    end
    issue = e_req && imem_gnt;
    if (redir) begin
      exp_q.delete();
      drop = drop + pend_q.size() - int'(rv);
      pend_q.delete();
      m_pc = rpc;
      m_halted = 0;
    end else begin
      if (e_valid && !stl) void'(exp_q.pop_front());
      if (rv) begin
        if (drop > 0) begin
          drop--;
        end else begin
          p = (pend_q.size() > 0) ? pend_q.pop_front() : 16'h0000;
          exp_q.push_back({rd, p, re});
          if (rd == 16'h0000) m_halted = 1;
          if (re) m_err = 1;
        end
      end
      if (issue) begin
        pend_q.push_back(m_pc);
        if (int'(m_pc) + 2 > 65535) m_err = 1;
        m_pc = m_pc + 16'd2;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_rerr = 1'b0;
    do_reset();

    // back-to-back stream from a 1-cycle memory
    repeat (10) cycle(1'b0, 16'h0, 1'b0);
    // stall until the queue fills, then drain
    repeat (5) cycle(1'b0, 16'h0, 1'b1);
    repeat (6) cycle(1'b0, 16'h0, 1'b0);

    // redirect with responses still in flight
    lat_max = 2;
    repeat (4) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h0100, 1'b0);
    repeat (8) cycle(1'b0, 16'h0, 1'b0);

    // HALT at PC 6, then resume via redirect
    lat_max = 0;
    halt_addr = 16'h0006;
    cycle(1'b1, 16'h0000, 1'b0);
    repeat (12) cycle(1'b0, 16'h0, 1'b0);
    halt_addr = 16'hFFFF;
    cycle(1'b1, 16'h0020, 1'b0);
    repeat (8) cycle(1'b0, 16'h0, 1'b0);

    // response error at PC 4 is sticky
    err_addr = 16'h0004;
    cycle(1'b1, 16'h0000, 1'b0);
    repeat (8) cycle(1'b0, 16'h0, 1'b0);
    err_addr = 16'hFFFF;
    do_reset();

    // fetch PC wraps past 0xFFFE
    cycle(1'b1, 16'hFFFC, 1'b0);
    repeat (6) cycle(1'b0, 16'h0, 1'b0);
    do_reset();

    // redirect and pop together on a full queue
    repeat (3) cycle(1'b0, 16'h0, 1'b0);
    repeat (6) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'h0040, 1'b0);
    repeat (4) cycle(1'b0, 16'h0, 1'b0);

    // random traffic
    gnt_pct = 70;
    lat_max = 3;
    halt_addr = 16'h0046;
    for (int i = 0; i < 400; i++) begin
      if (i == 250) err_addr = 16'h0030;
      cycle($urandom_range(0, 19) == 0, 16'($urandom_range(0, 63) * 2), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
